// File: rtl/soc_port_pwm.sv
// soc_port_pwm: byte-bus output port, per-channel direct level, PWM dimming or blink.
// Latency: read data and port_o one cycle after the strobe/edge; no backpressure, every strobe is accepted.
module soc_port_pwm #(
    parameter int          CHANNELS    = 8,
    parameter int          PWM_BITS    = 8,
    parameter int          BLINK_BITS  = 24,
    parameter logic [7:0]  INVERT_MASK = 8'h00
) (
    input  logic                clk_48mhz,
    input  logic                reset,
    input  logic [3:0]          addr_i,
    input  logic                wr_en_i,
    input  logic                rd_en_i,
    input  logic [7:0]          data_i,
    output logic [7:0]          data_o,
    output logic                rd_valid_o,
    output logic [CHANNELS-1:0] port_o
);

    localparam logic [3:0]          ADDR_OUT      = 4'h0;
    localparam logic [3:0]          ADDR_BLINK_EN = 4'h1;
    localparam logic [3:0]          ADDR_PWM_EN   = 4'h2;
    localparam logic [3:0]          ADDR_PRESCALE = 4'h3;
    localparam logic [3:0]          ADDR_BLINK_SEL = 4'h4;
    localparam logic [4:0]          SEL_MAX       = 5'(BLINK_BITS - 1);
    localparam logic [CHANNELS-1:0] INV           = INVERT_MASK[CHANNELS-1:0];

    logic [CHANNELS-1:0]   out_reg;
    logic [CHANNELS-1:0]   blink_en;
    logic [CHANNELS-1:0]   pwm_en;
    logic [7:0]            prescale;
    logic [4:0]            blink_sel;
    logic [PWM_BITS-1:0]   duty     [CHANNELS];
    logic [PWM_BITS-1:0]   duty_act [CHANNELS];

    logic [7:0]            pre_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [BLINK_BITS-1:0] blink_shift;

    logic                  tick;
    logic [4:0]            sel_c;
    logic                  phase;
    logic [CHANNELS-1:0]   lvl;
    logic [7:0]            rd_mux;

    always_comb begin
        tick        = (pre_cnt == prescale);
        sel_c       = (blink_sel > SEL_MAX) ? SEL_MAX : blink_sel;
        blink_shift = blink_cnt >> sel_c;
        phase       = blink_shift[0];
    end

    always_comb begin
        lvl = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            lvl[n] = pwm_en[n] ? (pwm_cnt < duty_act[n]) : out_reg[n];
            if (blink_en[n]) begin
                lvl[n] = lvl[n] & phase;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_OUT:       rd_mux[CHANNELS-1:0] = out_reg;
            ADDR_BLINK_EN:  rd_mux[CHANNELS-1:0] = blink_en;
            ADDR_PWM_EN:    rd_mux[CHANNELS-1:0] = pwm_en;
            ADDR_PRESCALE:  rd_mux               = prescale;
            ADDR_BLINK_SEL: rd_mux[4:0]          = blink_sel;
            default: begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (addr_i == 4'(8 + n)) begin
                        rd_mux[PWM_BITS-1:0] = duty[n];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            out_reg   <= '0;
            blink_en  <= '0;
            pwm_en    <= '0;
            prescale  <= '0;
            blink_sel <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                duty[n] <= '0;
            end
        end else if (wr_en_i) begin
            case (addr_i)
                ADDR_OUT:       out_reg   <= data_i[CHANNELS-1:0];
                ADDR_BLINK_EN:  blink_en  <= data_i[CHANNELS-1:0];
                ADDR_PWM_EN:    pwm_en    <= data_i[CHANNELS-1:0];
                ADDR_PRESCALE:  prescale  <= data_i;
                ADDR_BLINK_SEL: blink_sel <= data_i[4:0];
                default: begin
                    for (int n = 0; n < CHANNELS; n++) begin
                        if (addr_i == 4'(8 + n)) begin
                            duty[n] <= data_i[PWM_BITS-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // Active duties only change on the wrap tick so a period is never cut short.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                duty_act[n] <= '0;
            end
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if ((wr_en_i && addr_i == ADDR_PRESCALE) || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_cnt == '1) begin
                    duty_act <= duty;
                end
            end
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            data_o     <= '0;
            rd_valid_o <= 1'b0;
            port_o     <= INV;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                data_o <= rd_mux;
            end
            port_o <= lvl ^ INV;
        end
    end

endmodule
